dsha_nonce_scheduler: RTL and testbench
=======================================

// Module: dsha_nonce_scheduler
// PURPOSE
//  Sequences the double-SHA finisher: accepts work packets (X midstate, Y tail, nonce range) from the UART
//  receiver, sweeps the nonce into the finisher one per accepted cycle, and screens each finisher output
//  against a leading-zero target. Passing (hash, nonce) pairs are buffered in a small FIFO for the UART
//  transmitter. Sits between uart_multibyte_receiver, dsha_finisher and uart_multibyte_transmitter.
// PARAMETERS
//  ZERO_BITS   24  required leading zero bits of hash[255:0] (hash[255 -: ZERO_BITS] == 0)
//  PIPE_DEPTH  64  finisher latency in cycles; length of the post-load stale-result suppression window
//  FIFO_LOG    1   log2 result FIFO depth (default 2 entries)
// PORTS
//  clk             in   1    system clock (10 MHz)
//  rst             in   1    synchronous, active-high reset
//  work_valid      in   1    work packet available (level; held until work_ack)
//  work_x          in   256  midstate X
//  work_y          in   96   tail Y
//  work_nonce_lo   in   32   first nonce of the range
//  work_nonce_hi   in   32   last nonce of the range, inclusive
//  work_ack        out  1    1-cycle pulse: packet latched
//  dsha_x          out  256  registered X to the finisher
//  dsha_y          out  96   registered Y to the finisher
//  dsha_nonce      out  32   nonce offered to the finisher
//  dsha_accepted   in   1    finisher took dsha_nonce this cycle
//  dsha_hash       in   256  finisher output hash
//  dsha_out_nonce  in   32   nonce belonging to dsha_hash
//  res_valid       out  1    FIFO not empty
//  res_hash        out  256  head-entry hash
//  res_nonce       out  32   head-entry nonce
//  res_ready       in   1    consumer pops the head when res_valid & res_ready
//  busy            out  1    state == RUN
//  done            out  1    state == DONE (range exhausted)
//  found_cnt       out  16   results pushed since reset (saturating)
//  drop_cnt        out  16   results dropped on FIFO full (saturating)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including dsha_x/y/nonce; FIFO empty; counters 0; drain counter 0.
//  FSM: IDLE -(work_valid)-> RUN; RUN -(dsha_accepted & dsha_nonce==hi)-> DONE; RUN/DONE -(work_valid)-> RUN
//   (preempts the current sweep); DONE holds with dsha_nonce frozen.
//  Load: when work_valid is seen in any state, the next edge latches x/y, dsha_nonce<=lo, stores hi,
//   pulses work_ack for exactly 1 cycle, and sets drain<=PIPE_DEPTH. The packet is consumed once;
//   work_valid still high on the ack cycle is ignored.
//  Sweep: in RUN, dsha_accepted=1 -> dsha_nonce+1 next cycle (mod 2^32). Range with hi<lo wraps through 0.
//   lo==hi sweeps exactly one nonce. Load has priority over increment in the same cycle.
//  Screening: an output is new when dsha_out_nonce != last screened nonce (registered; reset 0, reload
//   on load clears it to ~lo). New outputs are ignored while drain!=0; drain decrements every cycle.
//   Screening continues in DONE so that the pipeline tail is not lost.
//  Push: new & drain==0 & hash[255 -: ZERO_BITS]==0 -> push {hash, out_nonce}; found_cnt++.
//   If full and no pop that cycle -> drop, drop_cnt++. If full with a simultaneous pop, push succeeds.
//   Pop and push on an empty FIFO: the entry is written; res_valid rises next cycle (no bypass).
//  Result latency: 1 cycle from the qualifying dsha output to res_valid (when the FIFO was empty).
//  rst mid-sweep: returns to IDLE within 1 cycle and flushes the FIFO; the finisher is not reset by this block.
// STRUCTURE
//  Shared package/header dsha_pkg: state encodings (ST_IDLE/ST_RUN/ST_DONE), widths
//   (HASH_W=256, X_W=256, Y_W=96, NONCE_W=32), and the zero-target compare function.
//  One sub-module: dsha_result_fifo (synchronous FIFO of width 288, depth 2**FIFO_LOG, full/empty flags,
//   push/pop in the same cycle). FSM, nonce counter, drain counter and screening remain in the top.
// TESTING
//  1 Reset: rst for 3 cycles -> all outputs 0, res_valid=0, state IDLE, work_ack never pulses.
//  2 Load lo=32'h10, hi=32'h13, accepted tied to 1 -> dsha_nonce 10,11,12,13, then done=1 with the nonce held
//    at 13; work_ack is a single 1-cycle pulse.
//  3 Model finisher with PIPE_DEPTH=4; hash with 24 top zeros for nonce 32'hb2957c02 -> exactly one entry,
//    res_nonce=b2957c02; found_cnt=1; hash with only 23 top zeros -> no push.
//  4 Wrap: lo=32'hFFFFFFFE, hi=32'h1 -> nonces FFFFFFFE, FFFFFFFF, 0, 1, then DONE.
//  5 Preempt: new work mid-sweep -> old-nonce qualifying hashes in the next PIPE_DEPTH cycles are not pushed;
//    dsha_nonce restarts at the new lo.
//  6 FIFO_LOG=1, res_ready=0, 3 qualifying outputs -> 2 stored, drop_cnt=1; a push with a same-cycle pop
//    while full -> no drop.

Source files
------------

// File: rtl/dsha_pkg.sv
// Shared types, widths and the leading-zero target check
// for the double-SHA nonce scheduler.
package dsha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int HASH_W  = 256;
    localparam int X_W     = 256;
    localparam int Y_W     = 96;
    localparam int NONCE_W = 32;
    localparam int RES_W   = HASH_W + NONCE_W;

    // True when the top zb bits of h are all zero.
    function automatic logic zero_ok(
        input logic [HASH_W-1:0] h,
        input int unsigned       zb
    );
        logic [HASH_W-1:0] m;
        m = ~({HASH_W{1'b1}} >> zb);
        return (h & m) == '0;
    endfunction

endpackage

// File: rtl/dsha_nonce_scheduler_if.sv
// Work-in / result-out channels of the nonce scheduler.
// master = UART side, slave = scheduler.
interface dsha_nonce_scheduler_if;
    import dsha_pkg::*;

    logic               work_valid;
    logic [X_W-1:0]     work_x;
    logic [Y_W-1:0]     work_y;
    logic [NONCE_W-1:0] work_nonce_lo;
    logic [NONCE_W-1:0] work_nonce_hi;
    logic               work_ack;

    logic               res_valid;
    logic [HASH_W-1:0]  res_hash;
    logic [NONCE_W-1:0] res_nonce;
    logic               res_ready;

    modport master (
        output work_valid, work_x, work_y,
        output work_nonce_lo, work_nonce_hi,
        input  work_ack,
        input  res_valid, res_hash, res_nonce,
        output res_ready
    );

    modport slave (
        input  work_valid, work_x, work_y,
        input  work_nonce_lo, work_nonce_hi,
        output work_ack,
        output res_valid, res_hash, res_nonce,
        input  res_ready
    );

endinterface

// File: rtl/dsha_result_fifo.sv
// Small synchronous FIFO holding {hash, nonce} results.
// A push while full only lands when a pop happens in the same cycle.
module dsha_result_fifo
    import dsha_pkg::*;
#(
    parameter int LOG = 1,
    parameter int W   = RES_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int D = 2 ** LOG;

    logic [W-1:0]   mem [D];
    logic [LOG-1:0] wp;
    logic [LOG-1:0] rp;
    logic [LOG:0]   cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (LOG + 1)'(D));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + LOG'(1);
            end
            if (do_pop) rp <= rp + LOG'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (LOG + 1)'(1);
                2'b01:   cnt <= cnt - (LOG + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dsha_nonce_scheduler.sv
// Feeds nonce ranges into the double-SHA finisher and
// screens its outputs against the leading-zero target.
module dsha_nonce_scheduler
    import dsha_pkg::*;
#(
    parameter int ZERO_BITS  = 24,
    parameter int PIPE_DEPTH = 64,
    parameter int FIFO_LOG   = 1
) (
    input  logic                clk,
    input  logic                rst,
    dsha_nonce_scheduler_if.slave wif,
    output logic [X_W-1:0]      dsha_x,
    output logic [Y_W-1:0]      dsha_y,
    output logic [NONCE_W-1:0]  dsha_nonce,
    input  logic                dsha_accepted,
    input  logic [HASH_W-1:0]   dsha_hash,
    input  logic [NONCE_W-1:0]  dsha_out_nonce,
    output logic                busy,
    output logic                done,
    output logic [15:0]         found_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int DW = $clog2(PIPE_DEPTH + 1);

    state_t             state;
    logic [NONCE_W-1:0] hi_r;
    logic [NONCE_W-1:0] last_nonce;
    logic [DW-1:0]      drain;
    logic               ack;
    logic               load;
    logic               fresh;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;
    logic               stored;
    logic [RES_W-1:0]   dout;

    assign load   = wif.work_valid & ~ack;
    assign fresh  = (state != ST_IDLE)
                  & (dsha_out_nonce != last_nonce)
                  & (drain == '0);
    assign push   = fresh & zero_ok(dsha_hash, ZERO_BITS);
    assign pop    = wif.res_valid & wif.res_ready;
    assign drop   = push & full & ~pop;
    assign stored = push & ~drop;

    assign wif.work_ack  = ack;
    assign wif.res_valid = ~empty;
    assign {wif.res_hash, wif.res_nonce} = dout;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dsha_x     <= '0;
            dsha_y     <= '0;
            dsha_nonce <= '0;
            hi_r       <= '0;
            last_nonce <= '0;
            drain      <= '0;
            ack        <= 1'b0;
            found_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            ack <= load;
            if (load) begin
                state      <= ST_RUN;
                dsha_x     <= wif.work_x;
                dsha_y     <= wif.work_y;
                dsha_nonce <= wif.work_nonce_lo;
                hi_r       <= wif.work_nonce_hi;
                last_nonce <= ~wif.work_nonce_lo;
                drain      <= DW'(PIPE_DEPTH);
            end else begin
                last_nonce <= dsha_out_nonce;
                if (drain != '0) drain <= drain - DW'(1);
                // Last accepted nonce parks the sweep; no increment past hi.
                if (state == ST_RUN && dsha_accepted) begin
                    if (dsha_nonce == hi_r) state <= ST_DONE;
                    else dsha_nonce <= dsha_nonce + 32'd1;
                end
            end
            if (stored && found_cnt != 16'hFFFF)
                found_cnt <= found_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    dsha_result_fifo #(
        .LOG (FIFO_LOG),
        .W   (RES_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({dsha_hash, dsha_out_nonce}),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_dsha_nonce_scheduler.sv
// Directed bench for dsha_nonce_scheduler with a 4-deep
// finisher model whose hash depends on the nonce.
module tb_dsha_nonce_scheduler;
    import dsha_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [X_W-1:0]     dsha_x;
    logic [Y_W-1:0]     dsha_y;
    logic [NONCE_W-1:0] dsha_nonce;
    logic               dsha_accepted = 1'b1;
    logic [HASH_W-1:0]  dsha_hash;
    logic [NONCE_W-1:0] dsha_out_nonce;
    logic               busy;
    logic               done;
    logic [15:0]        found_cnt;
    logic [15:0]        drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] g0  = 32'hDEADBEEF;
    logic [31:0] g1  = 32'hDEADBEEF;
    logic [31:0] g2  = 32'hDEADBEEF;
    logic [31:0] b23 = 32'hDEADBEEF;

    logic [31:0] pipe [4] = '{default: 32'h0};

    dsha_nonce_scheduler_if bus ();

    dsha_nonce_scheduler #(
        .ZERO_BITS  (24),
        .PIPE_DEPTH (4),
        .FIFO_LOG   (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wif            (bus),
        .dsha_x         (dsha_x),
        .dsha_y         (dsha_y),
        .dsha_nonce     (dsha_nonce),
        .dsha_accepted  (dsha_accepted),
        .dsha_hash      (dsha_hash),
        .dsha_out_nonce (dsha_out_nonce),
        .busy           (busy),
        .done           (done),
        .found_cnt      (found_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    // Finisher model: 4-cycle latency, not reset by the scheduler.
    always @(posedge clk) begin
        if (dsha_accepted) begin
            pipe[0] <= dsha_nonce;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end
    end

    function automatic logic [255:0] hash_of(
        input logic [31:0] n, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c,
        input logic [31:0] d
    );
        if (n == a || n == b || n == c)
            return {24'h0, n, 200'h1};
        if (n == d)
            return {23'h0, 1'b1, n, 200'h1};
        return {24'hFFFFFF, n, 200'h1};
    endfunction

    assign dsha_out_nonce = pipe[3];
    assign dsha_hash = hash_of(pipe[3], g0, g1, g2, b23);

    task automatic check(
        input string tag,
        input logic [255:0] obs,
        input logic [255:0] exp
    );
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_work(input logic [31:0] lo, input logic [31:0] hi);
        bus.work_valid    = 1'b1;
        bus.work_x        = {8{lo}};
        bus.work_y        = {3{hi}};
        bus.work_nonce_lo = lo;
        bus.work_nonce_hi = hi;
        @(negedge clk);
        check("load_ack", 256'(bus.work_ack), 256'(1));
        check("load_lo", 256'(dsha_nonce), 256'(lo));
        check("load_x", 256'(dsha_x), {8{lo}});
        bus.work_valid = 1'b0;
    endtask

    logic [31:0] wrap_exp [3] = '{32'hFFFFFFFF, 32'h0, 32'h1};

    initial begin
        rst               = 1'b1;
        bus.work_valid    = 1'b1;
        bus.work_x        = '1;
        bus.work_y        = '1;
        bus.work_nonce_lo = 32'h5;
        bus.work_nonce_hi = 32'h9;
        bus.res_ready     = 1'b0;

        // reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ack", 256'(bus.work_ack), 256'(0));
        end
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_nonce", 256'(dsha_nonce), 256'(0));
        check("rst_x", dsha_x, 256'(0));
        check("rst_y", 256'(dsha_y), 256'(0));
        check("rst_rv", 256'(bus.res_valid), 256'(0));
        check("rst_rh", bus.res_hash, 256'(0));
        check("rst_found", 256'(found_cnt), 256'(0));
        check("rst_drop", 256'(drop_cnt), 256'(0));
        rst = 1'b0;
        bus.work_valid = 1'b0;

        // basic sweep 10..13
        load_work(32'h10, 32'h13);
        check("t2_busy", 256'(busy), 256'(1));
        check("t2_y", 256'(dsha_y), 256'({3{32'h13}}));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("t2_sweep", 256'(dsha_nonce), 256'(32'h10 + i));
            check("t2_ack", 256'(bus.work_ack), 256'(0));
        end
        @(negedge clk);
        check("t2_done", 256'(done), 256'(1));
        check("t2_busy0", 256'(busy), 256'(0));
        check("t2_hold", 256'(dsha_nonce), 256'(32'h13));
        @(negedge clk);
        check("t2_hold2", 256'(dsha_nonce), 256'(32'h13));

        // screening: 24 zeros pushes, 23 zeros does not
        g0  = 32'hb2957c02;
        b23 = 32'hb2957c03;
        load_work(32'hb2957c00, 32'hb2957c03);
        repeat (6) @(negedge clk);
        check("t3_lat0", 256'(bus.res_valid), 256'(0));
        @(negedge clk);
        check("t3_rv", 256'(bus.res_valid), 256'(1));
        check("t3_nonce", 256'(bus.res_nonce), 256'(32'hb2957c02));
        check("t3_hash", bus.res_hash,
              {24'h0, 32'hb2957c02, 200'h1});
        repeat (2) @(negedge clk);
        check("t3_found", 256'(found_cnt), 256'(1));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("t3_23bit", 256'(bus.res_valid), 256'(0));
        g0  = 32'hDEADBEEF;
        b23 = 32'hDEADBEEF;

        // wrap through zero
        load_work(32'hFFFFFFFE, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_wrap", 256'(dsha_nonce), 256'(wrap_exp[i]));
        end
        @(negedge clk);
        check("t4_done", 256'(done), 256'(1));
        check("t4_hold", 256'(dsha_nonce), 256'(32'h1));

        // preempt: stale 100/101 suppressed, 201 pushed
        g0 = 32'h100;
        g1 = 32'h101;
        g2 = 32'h201;
        load_work(32'h100, 32'h1FF);
        @(negedge clk);
        load_work(32'h200, 32'h20F);
        repeat (5) @(negedge clk);
        check("t5_stale", 256'(bus.res_valid), 256'(0));
        @(negedge clk);
        check("t5_rv", 256'(bus.res_valid), 256'(1));
        check("t5_nonce", 256'(bus.res_nonce), 256'(32'h201));
        check("t5_found", 256'(found_cnt), 256'(2));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("t5_pop", 256'(bus.res_valid), 256'(0));

        // FIFO overflow: 3 hits, 2 stored, 1 dropped
        g0 = 32'h301;
        g1 = 32'h302;
        g2 = 32'h303;
        load_work(32'h300, 32'h305);
        repeat (10) @(negedge clk);
        check("t6_rv", 256'(bus.res_valid), 256'(1));
        check("t6_head", 256'(bus.res_nonce), 256'(32'h301));
        check("t6_drop", 256'(drop_cnt), 256'(1));
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("t6_head2", 256'(bus.res_nonce), 256'(32'h302));
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("t6_empty", 256'(bus.res_valid), 256'(0));

        // full with a same-cycle pop: push lands, no drop
        g0 = 32'h401;
        g1 = 32'h402;
        g2 = 32'h403;
        load_work(32'h400, 32'h405);
        repeat (7) @(negedge clk);
        check("t6b_full", 256'(bus.res_nonce), 256'(32'h401));
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("t6b_drop", 256'(drop_cnt), 256'(1));
        check("t6b_head", 256'(bus.res_nonce), 256'(32'h402));
        @(negedge clk);
        check("t6b_tail", 256'(bus.res_nonce), 256'(32'h403));
        check("t6b_rv", 256'(bus.res_valid), 256'(1));
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("t6b_empty", 256'(bus.res_valid), 256'(0));

        // reset mid-sweep flushes the FIFO
        g0 = 32'h501;
        g1 = 32'hDEADBEEF;
        g2 = 32'hDEADBEEF;
        load_work(32'h500, 32'h5FF);
        repeat (8) @(negedge clk);
        check("t7_rv", 256'(bus.res_valid), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_busy", 256'(busy), 256'(0));
        check("t7_rv0", 256'(bus.res_valid), 256'(0));
        check("t7_nonce", 256'(dsha_nonce), 256'(0));
        check("t7_found", 256'(found_cnt), 256'(0));
        check("t7_drop", 256'(drop_cnt), 256'(0));
        repeat (3) @(negedge clk);
        check("t7_idle", 256'(busy), 256'(0));
        check("t7_idle_rv", 256'(bus.res_valid), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
